// File: rtl/ram_arbiter_if.sv
// Cache-side and RAM-side bus bundle for ram_arbiter; cache buses are flattened,
// port i occupying bits [i*W +: W].
interface ram_arbiter_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   logic [4*ADDR_W-1:0] m_addr;
   logic [4*DATA_W-1:0] m_data_w;
   logic [3:0]          m_read;
   logic [3:0]          m_write;
   logic [3:0]          m_atomic;
   logic [3:0]          m_wait;
   logic [4*DATA_W-1:0] m_data_r;
   logic [3:0]          m_permit;
   logic [ADDR_W-1:0]   ram_addr;
   logic [DATA_W-1:0]   ram_data_w;
   logic                ram_read;
   logic                ram_write;
   logic                ram_wait;
   logic [DATA_W-1:0]   ram_data_r;

   // Arbiter view.
   modport slave (
      input  m_addr, m_data_w, m_read, m_write, m_atomic, ram_wait, ram_data_r,
      output m_wait, m_data_r, m_permit, ram_addr, ram_data_w, ram_read, ram_write
   );

   // Caches plus shared RAM, as seen from outside the arbiter.
   modport master (
      output m_addr, m_data_w, m_read, m_write, m_atomic, ram_wait, ram_data_r,
      input  m_wait, m_data_r, m_permit, ram_addr, ram_data_w, ram_read, ram_write
   );
endinterface

// File: rtl/ram_arbiter.sv
// Four-port round-robin arbiter in front of a single shared RAM.
// Define ARB_ATOMIC_LOCK_EN to let an atomic cache keep the bus across accesses.
module ram_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input logic          clk,
   input logic          clr_n,
   ram_arbiter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StRelease} state_e;

   state_e              state_q, state_d;
   logic [1:0]          grant_q, grant_d;
   logic [1:0]          last_q, last_d;
   logic [4*DATA_W-1:0] data_r_q, data_r_d;

   logic [3:0] req;
   logic [1:0] pick;
   logic       pick_vld;
   logic       g_req, g_write, g_read;

   assign req     = bus.m_read | bus.m_write;
   assign g_req   = req[grant_q];
   assign g_write = bus.m_write[grant_q];
   // Both strobes high is treated as a write.
   assign g_read  = bus.m_read[grant_q] & ~g_write;

`ifdef ARB_ATOMIC_LOCK_EN
   logic g_atomic;
   assign g_atomic = bus.m_atomic[grant_q];
`else
   logic unused_atomic;
   assign unused_atomic = ^bus.m_atomic;
`endif

   // Scan last+4 down to last+1 so the port right after last wins.
   always_comb begin
      logic [1:0] idx;
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int k = 4; k >= 1; k--) begin
         idx = last_q + 2'(k);
         if (req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      last_d   = last_q;
      data_r_d = data_r_q;
      unique case (state_q)
         StIdle: begin
            if (pick_vld) begin
               grant_d = pick;
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (!g_req) begin
               state_d = StIdle;
               last_d  = grant_q;
            end else if (!bus.ram_wait) begin
               if (g_read) begin
                  data_r_d[grant_q*DATA_W +: DATA_W] = bus.ram_data_r;
               end
               state_d = StRelease;
            end
         end
         StRelease: begin
            state_d = StIdle;
            last_d  = grant_q;
`ifdef ARB_ATOMIC_LOCK_EN
            if (g_atomic && g_req) begin
               state_d = StAccess;
               last_d  = last_q;
            end
`endif
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q  <= StIdle;
         grant_q  <= 2'd0;
         last_q   <= 2'd3;
         data_r_q <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         last_q   <= last_d;
         data_r_q <= data_r_d;
      end
   end

   // RAM side is a pure mux of the granted port, forced to zero outside an access.
   always_comb begin
      bus.ram_addr   = '0;
      bus.ram_data_w = '0;
      bus.ram_read   = 1'b0;
      bus.ram_write  = 1'b0;
      if (state_q == StAccess) begin
         bus.ram_addr   = bus.m_addr[grant_q*ADDR_W +: ADDR_W];
         bus.ram_data_w = bus.m_data_w[grant_q*DATA_W +: DATA_W];
         bus.ram_read   = g_read;
         bus.ram_write  = g_write;
      end
   end

   always_comb begin
      bus.m_wait   = '0;
      bus.m_permit = '0;
      for (int i = 0; i < 4; i++) begin
         bus.m_wait[i]   = req[i] & ~((state_q == StRelease) && (grant_q == 2'(i)));
         bus.m_permit[i] = (state_q != StIdle) && (grant_q == 2'(i));
      end
   end

   assign bus.m_data_r = data_r_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter; expectations follow ARB_ATOMIC_LOCK_EN.
module tb_ram_arbiter;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;

   logic clk = 1'b0;
   logic clr_n;
   int   tests = 0;
   int   fails = 0;

   ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.m_addr     = '0;
      bus.m_data_w   = '0;
      bus.m_read     = '0;
      bus.m_write    = '0;
      bus.m_atomic   = '0;
      bus.ram_wait   = 1'b0;
      bus.ram_data_r = '0;
   endtask

   task automatic set_addr(input int p, input logic [31:0] a);
      bus.m_addr[p*AW +: AW] = a;
   endtask

   task automatic pulse_reset();
      clr_n = 1'b0;
      #1;
      clr_n = 1'b1;
   endtask

   logic [3:0] t3_perm [8] = '{4'h1, 4'h1, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8};
   logic [3:0] t3_wait [8] = '{4'hD, 4'hC, 4'hC, 4'hC, 4'h8, 4'h8, 4'h8, 4'h0};
   logic [3:0] t3_drop [8] = '{4'h0, 4'h1, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h8};
`ifdef ARB_ATOMIC_LOCK_EN
   logic [3:0] t4_perm [8] = '{4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0};
   logic [3:0] t4_drop [8] = '{4'h0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h0, 4'h1, 4'h0};
`else
   logic [3:0] t4_perm [8] = '{4'h4, 4'h4, 4'h0, 4'h1, 4'h1, 4'h0, 4'h4, 4'h4};
   logic [3:0] t4_drop [8] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h4};
`endif

   initial begin
      // Reset state
      clr_n = 1'b0;
      clear_inputs();
      @(negedge clk);
      chk("rst_permit", 128'(bus.m_permit), 128'(0));
      chk("rst_read", 128'(bus.ram_read), 128'(0));
      chk("rst_write", 128'(bus.ram_write), 128'(0));
      chk("rst_addr", 128'(bus.ram_addr), 128'(0));
      chk("rst_wdata", 128'(bus.ram_data_w), 128'(0));
      chk("rst_data_r", 128'(bus.m_data_r), 128'(0));

      // Port 0 read, zero wait
      clr_n          = 1'b1;
      bus.m_read[0]  = 1'b1;
      set_addr(0, 32'h27);
      bus.ram_data_r = 32'h45B;
      @(negedge clk);
      chk("t1_read", 128'(bus.ram_read), 128'(1));
      chk("t1_addr", 128'(bus.ram_addr), 128'(32'h27));
      chk("t1_wait_acc", 128'(bus.m_wait), 128'(4'b0001));
      @(negedge clk);
      chk("t1_data", 128'(bus.m_data_r[31:0]), 128'(32'h45B));
      chk("t1_wait_rel", 128'(bus.m_wait), 128'(4'b0000));
      chk("t1_read_rel", 128'(bus.ram_read), 128'(0));
      bus.m_read[0] = 1'b0;

      // Port 1 write with three wait cycles
      @(negedge clk);
      bus.m_write[1]         = 1'b1;
      set_addr(1, 32'h43);
      bus.m_data_w[63:32]    = 32'h1E61;
      bus.ram_wait           = 1'b1;
      bus.ram_data_r         = 32'hDEAD;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         chk($sformatf("t2_write%0d", k), 128'(bus.ram_write), 128'(1));
         chk($sformatf("t2_wait%0d", k), 128'(bus.m_wait), 128'(4'b0010));
         if (k == 1) begin
            chk("t2_addr", 128'(bus.ram_addr), 128'(32'h43));
            chk("t2_wdata", 128'(bus.ram_data_w), 128'(32'h1E61));
         end
         if (k == 4) bus.ram_wait = 1'b0;
      end
      @(negedge clk);
      chk("t2_wait_rel", 128'(bus.m_wait), 128'(4'b0000));
      chk("t2_permit_rel", 128'(bus.m_permit), 128'(4'b0010));
      chk("t2_no_capture", 128'(bus.m_data_r[63:32]), 128'(0));
      chk("t2_write_rel", 128'(bus.ram_write), 128'(0));
      bus.m_write[1] = 1'b0;

      // Simultaneous requests on 0, 2, 3 from reset
      @(negedge clk);
      pulse_reset();
      clear_inputs();
      bus.ram_data_r = 32'h777;
      bus.m_read     = 4'b1101;
      set_addr(0, 32'h10);
      set_addr(2, 32'h20);
      set_addr(3, 32'h30);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("t3_perm%0d", c), 128'(bus.m_permit), 128'(t3_perm[c]));
         chk($sformatf("t3_wait%0d", c), 128'(bus.m_wait), 128'(t3_wait[c]));
         bus.m_read = bus.m_read & ~t3_drop[c];
      end

      // Atomic port 2 with a competing port 0
      @(negedge clk);
      pulse_reset();
      clear_inputs();
      bus.m_read[2]   = 1'b1;
      bus.m_atomic[2] = 1'b1;
      set_addr(2, 32'h50);
      set_addr(0, 32'h60);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         chk($sformatf("t4_perm%0d", c), 128'(bus.m_permit), 128'(t4_perm[c]));
         if (c == 0) bus.m_read[0] = 1'b1;
         bus.m_read   = bus.m_read & ~t4_drop[c];
         bus.m_atomic = bus.m_atomic & ~t4_drop[c];
      end

      // Port 3 aborts mid-access, pending port 0 follows
      @(negedge clk);
      pulse_reset();
      clear_inputs();
      bus.m_read[3]  = 1'b1;
      set_addr(3, 32'h99);
      bus.ram_wait   = 1'b1;
      bus.ram_data_r = 32'hBAD;
      @(negedge clk);
      chk("t5_permit", 128'(bus.m_permit), 128'(4'b1000));
      chk("t5_read", 128'(bus.ram_read), 128'(1));
      bus.m_read[0] = 1'b1;
      set_addr(0, 32'h11);
      @(negedge clk);
      chk("t5_read_hold", 128'(bus.ram_read), 128'(1));
      bus.m_read[3] = 1'b0;
      @(negedge clk);
      chk("t5_abort_read", 128'(bus.ram_read), 128'(0));
      chk("t5_abort_permit", 128'(bus.m_permit), 128'(0));
      chk("t5_abort_data", 128'(bus.m_data_r[127:96]), 128'(0));
      chk("t5_abort_wait", 128'(bus.m_wait), 128'(4'b0001));
      @(negedge clk);
      chk("t5_p0_permit", 128'(bus.m_permit), 128'(4'b0001));
      chk("t5_p0_addr", 128'(bus.ram_addr), 128'(32'h11));
      bus.ram_wait   = 1'b0;
      bus.ram_data_r = 32'h5A5;
      @(negedge clk);
      chk("t5_p0_data", 128'(bus.m_data_r[31:0]), 128'(32'h5A5));
      chk("t5_p3_data", 128'(bus.m_data_r[127:96]), 128'(0));
      bus.m_read[0] = 1'b0;

      // Asynchronous reset during an access
      @(negedge clk);
      bus.m_read[1] = 1'b1;
      set_addr(1, 32'h33);
      bus.ram_wait  = 1'b1;
      @(negedge clk);
      chk("t6_read", 128'(bus.ram_read), 128'(1));
      bus.m_read[0] = 1'b1;
      clr_n         = 1'b0;
      #1;
      chk("t6_rst_read", 128'(bus.ram_read), 128'(0));
      chk("t6_rst_write", 128'(bus.ram_write), 128'(0));
      chk("t6_rst_permit", 128'(bus.m_permit), 128'(0));
      chk("t6_rst_data", 128'(bus.m_data_r), 128'(0));
      @(negedge clk);
      clr_n = 1'b1;
      @(negedge clk);
      chk("t6_p0_first", 128'(bus.m_permit), 128'(4'b0001));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Four-port round-robin arbiter between the per-core `my_cache` RAM-side ports and the single shared RAM. It sits directly downstream of the caches: it consumes their `ram_*` request strobes, serialises them onto one RAM port and returns read data and `ram_wait` back-pressure. It also drives the per-cache `arbiter_permit` line. When atomic locking is compiled in, it holds the bus for a cache performing an atomic sequence.

## Interface
Parameters:
- `ADDR_W`, 32, address width per port
- `DATA_W`, 32, data width per port

Ports. Master buses are flattened, with port i in bits `[i*W +: W]`.
- `clk`  in  1  rising-edge clock
- `clr_n`  in  1  asynchronous, active-low reset; one clock domain only
- `m_addr`  in  4*ADDR_W  cache `ram_addr`
- `m_data_w`  in  4*DATA_W  cache `ram_data_w`
- `m_read`  in  4  cache `ram_read`
- `m_write`  in  4  cache `ram_write`
- `m_atomic`  in  4  cache `cache_atomic_o`
- `m_wait`  out  4  to cache `ram_wait`
- `m_data_r`  out  4*DATA_W  to cache `ram_data_r`, registered per port
- `m_permit`  out  4  to cache `arbiter_permit`, one-hot or zero
- `ram_addr`  out  ADDR_W  shared RAM address
- `ram_data_w`  out  DATA_W  shared RAM write data
- `ram_read`  out  1  RAM read strobe
- `ram_write`  out  1  RAM write strobe
- `ram_wait`  in  1  RAM busy
- `ram_data_r`  in  DATA_W  RAM read data

## Operation
- `req[i] = m_read[i] | m_write[i]`. If both strobes are high, the access is treated as a write.
- State `IDLE`:
  - Pick the first `req[i]` scanning from `last+1` modulo 4.
  - Load `grant`, then go to `ACCESS`.
  - With no request, stay in `IDLE`.
- State `ACCESS`:
  - `ram_addr`, `ram_data_w`, `ram_read` and `ram_write` are a combinational mux of the granted port; `ram_read` and `ram_write` are both 0 in every other state.
  - When `ram_wait`==0, the access completes. A read captures `ram_data_r` into `m_data_r[grant]`; a write leaves `m_data_r` unchanged. Go to `RELEASE`.
  - If the granted port drops `req` while in `ACCESS`, abort: strobes go low and the next state is `IDLE`. `m_data_r` is not updated and `last` is updated.
- State `RELEASE`:
  - One cycle with `m_wait[grant]`=0, the completion indication to the cache.
  - Next state is `IDLE`, and `last` is set to `grant`.
  - Exception (lock hold): with the lock feature enabled, `m_atomic[grant]`=1 and `req[grant]`=1, go straight back to `ACCESS` with the same grant and leave `last` unchanged.
- `m_wait[i]` = `req[i]` & !(state==`RELEASE` & grant==i). A non-requesting port sees 0.
- `m_permit[i]` = 1 while state is `ACCESS` or `RELEASE` and grant==i; 0 otherwise.
- A request still high after `RELEASE` is a new request and is re-arbitrated.

## Timing
- Reset values:
  - state `IDLE`, `grant`=0, `last`=3 (port 0 has first priority)
  - all `m_data_r`=0, `m_permit`=0
  - `ram_read`=`ram_write`=0
  - `ram_addr`=`ram_data_w`=0 (mux output is forced to 0 outside `ACCESS`)
- Minimum latency, request to completion cycle:
  - request sampled at edge 0
  - `ACCESS` during cycle 1; if `ram_wait`=0, complete at edge 2
  - `RELEASE` during cycle 2, with `m_data_r` valid and `m_wait` low
  - 3 cycles total, plus 1 cycle for every cycle `ram_wait` stays high.
- Simultaneous requests in `IDLE`: only one is granted. The others see `m_wait`=1 until their own `RELEASE`.
- Round-robin wrap: `last`=3 scans ports 0,1,2,3.
- `clr_n` low mid-`ACCESS`: strobes drop asynchronously, and no data is captured.

## Configuration
- `ARB_ATOMIC_LOCK_EN` defined:
  - the `RELEASE`→`ACCESS` lock hold is active
  - another port cannot win the bus until the atomic port drops `m_atomic` or `req`.
- `ARB_ATOMIC_LOCK_EN` undefined:
  - `m_atomic` is ignored, and every `RELEASE` returns to `IDLE`
  - pure round-robin.

## Test plan
- Reset, then port 0 reads `0x27` with `ram_wait`=0 and `ram_data_r`=`0x45B`.
  - `ram_read`=1 and `ram_addr`=`0x27` in cycle 1; `m_data_r[0]`=`0x45B` and `m_wait[0]`=0 in cycle 2.
- Port 1 writes `0x1E61` to `0x43` with `ram_wait` high for 3 cycles.
  - `ram_write` is held 4 cycles; `m_wait[1]` stays 1 until `RELEASE`; `m_data_r[1]` is unchanged.
- Ports 0, 2 and 3 all request at once from reset.
  - Grant order 0, 2, 3; each port sees `m_permit` one-hot only during its own ownership.
- With `ARB_ATOMIC_LOCK_EN`, port 2 holds `m_atomic`=1 for 2 reads while port 0 requests.
  - Both port-2 accesses complete back-to-back before port 0 is granted.
  - Without the macro, port 0 is granted between the two port-2 reads.
- Port 3 drops `m_read` mid-`ACCESS` with `ram_wait`=1.
  - Strobes go low the next cycle and `m_data_r[3]` is unchanged.
  - A pending port-0 request is granted next.
- Assert `clr_n`=0 during `ACCESS`.
  - `ram_read`, `ram_write` and `m_permit` go 0 immediately; after release, port 0 has priority.
